song_sequencer: RTL and testbench

Parametrised successor to the music-player control unit. Selects the current song index among NUM_SONGS and drives play/pause and a one-cycle player reset. Adds previous-song navigation, repeat modes, autoplay after song completion, and optional shuffle. Sits between the one-pulsed front-panel buttons and the song reader/note player.

---
 rtl/song_seq_pkg.sv | 24 ++
 rtl/song_lfsr.sv | 31 +++
 rtl/song_sequencer.sv | 128 ++++++++++++
 tb/tb_song_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_seq_pkg.sv
// Shared types and constants for the song sequencer: FSM states, repeat modes and LFSR setup.
// Pure declarations; no logic or latency of its own.
package song_seq_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  localparam logic [1:0] RPT_STOP = 2'd0;
  localparam logic [1:0] RPT_ALL  = 2'd1;
  localparam logic [1:0] RPT_ONE  = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1 (maximal length)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Encoding 3 is an alias of repeat-all
  function automatic logic is_rpt_all(input logic [1:0] mode);
    return (mode == RPT_ALL) || (mode == 2'd3);
  endfunction

endpackage

// File: rtl/song_lfsr.sv
// Free-running 8-bit Galois LFSR used as the shuffle source; steps every cycle, value is registered.
// No backpressure; synchronous active-low reset reloads the seed.
module song_lfsr
  import song_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[7:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/song_sequencer.sv
// Song selection and play/pause/restart control; outputs registered, one edge from inputs; no backpressure.
// Optional random next-song selection in repeat-all mode when SONG_SHUFFLE_EN is defined.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter  int NUM_SONGS = 4,
  localparam int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              song_done,
  input  logic              autoplay,
  input  logic [1:0]        repeat_mode,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              resume_q, resume_d;
  logic              play_q, play_d;
  logic              reset_player_q, reset_player_d;

  logic [SONG_W-1:0] inc_idx;
  logic [SONG_W-1:0] dec_idx;
  logic [SONG_W-1:0] adv_idx;

  assign inc_idx = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
  assign dec_idx = (song_q == '0) ? LAST_SONG : song_q - SONG_W'(1);

`ifdef SONG_SHUFFLE_EN
  logic [7:0]        lfsr;
  logic [8:0]        cand_w;
  logic [SONG_W-1:0] cand;
  logic [SONG_W-1:0] shuf_idx;

  song_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Bumping a collision by one keeps the pick in range and guarantees a change
  always_comb begin
    cand_w   = {1'b0, lfsr} % 9'(NUM_SONGS);
    cand     = SONG_W'(cand_w);
    shuf_idx = cand;
    if (cand == song_q) begin
      shuf_idx = (cand == LAST_SONG) ? '0 : cand + SONG_W'(1);
    end
    adv_idx = is_rpt_all(repeat_mode) ? shuf_idx : inc_idx;
  end
`else
  assign adv_idx = inc_idx;
`endif

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;

    if (state_q == ST_RESTART) begin
      state_d = resume_q ? ST_PLAYING : ST_PAUSED;
    end else if (next_button) begin
      song_d   = adv_idx;
      state_d  = ST_RESTART;
      resume_d = 1'b0;
    end else if (prev_button) begin
      song_d   = dec_idx;
      state_d  = ST_RESTART;
      resume_d = 1'b0;
    end else if (song_done && (state_q == ST_PLAYING)) begin
      state_d = ST_RESTART;
      case (repeat_mode)
        RPT_ONE: begin
          resume_d = 1'b1;
        end
        RPT_STOP: begin
          song_d   = inc_idx;
          resume_d = (song_q == LAST_SONG) ? 1'b0 : autoplay;
        end
        default: begin
          song_d   = adv_idx;
          resume_d = autoplay;
        end
      endcase
    end else if (play_button) begin
      state_d = (state_q == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
    end

    play_d         = (state_d == ST_PLAYING);
    reset_player_d = (state_d == ST_RESTART);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_PAUSED;
      song_q         <= '0;
      resume_q       <= 1'b0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      song_q         <= song_d;
      resume_q       <= resume_d;
      play_q         <= play_d;
      reset_player_q <= reset_player_d;
    end
  end

  assign play         = play_q;
  assign reset_player = reset_player_q;
  assign song         = song_q;

  a_song_in_range : assert property (@(posedge clk) disable iff (!reset)
    int'(song_q) < NUM_SONGS);
  a_restart_one_cycle : assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_RESTART) |=> (state_q != ST_RESTART));
  a_outputs_exclusive : assert property (@(posedge clk) disable iff (!reset)
    !(play_q && reset_player_q));

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a 4-song and a 5-song instance driven by directed vectors.
module tb_song_sequencer;

  typedef struct packed {
    logic       rst_n;
    logic       play;
    logic       next;
    logic       prev;
    logic       done;
    logic       ap;
    logic [1:0] rm;
  } in_t;

  typedef struct packed {
    logic [7:0] song;
    logic       play;
    logic       rp;
  } exp_t;

  localparam int C_IDLE = 0;
  localparam int C_RST  = 1;
  localparam int C_PLAY = 2;
  localparam int C_NEXT = 3;
  localparam int C_PREV = 4;
  localparam int C_DONE = 5;
  localparam int C_NXPL = 6;
  localparam int C_NXPV = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t        in4, in5;
  logic       play4, rp4, play5, rp5;
  logic [1:0] song4;
  logic [2:0] song5;

  exp_t q4[$];
  exp_t q5[$];
  int   checks = 0;
  int   errors = 0;
  int   idx4   = 0;
  int   idx5   = 0;

  song_sequencer #(.NUM_SONGS(4)) dut4 (
    .clk          (clk),
    .reset        (in4.rst_n),
    .play_button  (in4.play),
    .next_button  (in4.next),
    .prev_button  (in4.prev),
    .song_done    (in4.done),
    .autoplay     (in4.ap),
    .repeat_mode  (in4.rm),
    .play         (play4),
    .reset_player (rp4),
    .song         (song4)
  );

  song_sequencer #(.NUM_SONGS(5)) dut5 (
    .clk          (clk),
    .reset        (in5.rst_n),
    .play_button  (in5.play),
    .next_button  (in5.next),
    .prev_button  (in5.prev),
    .song_done    (in5.done),
    .autoplay     (in5.ap),
    .repeat_mode  (in5.rm),
    .play         (play5),
    .reset_player (rp5),
    .song         (song5)
  );

  function automatic in_t mk(input int c, input logic ap, input logic [1:0] rm);
    in_t v;
    v       = '0;
    v.rst_n = (c != C_RST);
    v.play  = (c == C_PLAY) || (c == C_NXPL);
    v.next  = (c == C_NEXT) || (c == C_NXPL) || (c == C_NXPV);
    v.prev  = (c == C_PREV) || (c == C_NXPV);
    v.done  = (c == C_DONE);
    v.ap    = ap;
    v.rm    = rm;
    return v;
  endfunction

  // Drive one cycle of stimulus on the selected instance and queue its expected outputs
  task automatic step(input bit sel, input int c, input logic ap, input logic [1:0] rm,
                      input logic [7:0] es, input logic ep, input logic er);
    exp_t e;
    @(negedge clk);
    e = '{song: es, play: ep, rp: er};
    if (sel) begin
      in5 = mk(c, ap, rm);
      in4 = mk(C_IDLE, 1'b0, 2'd0);
      q5.push_back(e);
    end else begin
      in4 = mk(c, ap, rm);
      in5 = mk(C_IDLE, 1'b0, 2'd0);
      q4.push_back(e);
    end
  endtask

  task automatic cmp(input string nm, input int n, input exp_t e,
                     input logic [7:0] s, input logic p, input logic r);
    checks++;
    if ((s !== e.song) || (p !== e.play) || (r !== e.rp)) begin
      errors++;
      $display("FAIL %s step %0d: got song=%0d play=%0b reset_player=%0b, expected song=%0d play=%0b reset_player=%0b",
               nm, n, s, p, r, e.song, e.play, e.rp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        cmp("dut4", idx4, e, {6'd0, song4}, play4, rp4);
        idx4++;
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        cmp("dut5", idx5, e, {5'd0, song5}, play5, rp5);
        idx5++;
      end
    end
  end

  initial begin
    in4 = mk(C_RST, 1'b0, 2'd0);
    in5 = mk(C_RST, 1'b0, 2'd0);
    repeat (2) @(negedge clk);

    // 4 songs: play toggle, next with wrap, repeat-stop handling, priority, reset in RESTART
    step(0, C_RST,  0, 0, 0, 0, 0);
    step(0, C_IDLE, 0, 0, 0, 0, 0);
    step(0, C_PLAY, 0, 0, 0, 1, 0);
    step(0, C_PLAY, 0, 0, 0, 0, 0);
    step(0, C_PLAY, 0, 0, 0, 1, 0);
    step(0, C_NEXT, 0, 0, 1, 0, 1);
    step(0, C_IDLE, 0, 0, 1, 0, 0);
    step(0, C_NEXT, 0, 0, 2, 0, 1);
    step(0, C_IDLE, 0, 0, 2, 0, 0);
    step(0, C_NEXT, 0, 0, 3, 0, 1);
    step(0, C_IDLE, 0, 0, 3, 0, 0);
    step(0, C_PLAY, 0, 0, 3, 1, 0);
    step(0, C_NEXT, 0, 0, 0, 0, 1);
    step(0, C_IDLE, 0, 0, 0, 0, 0);
    step(0, C_IDLE, 0, 0, 0, 0, 0);
    step(0, C_PREV, 0, 0, 3, 0, 1);
    step(0, C_IDLE, 0, 0, 3, 0, 0);
    step(0, C_PLAY, 1, 0, 3, 1, 0);
    step(0, C_DONE, 1, 0, 0, 0, 1);
    step(0, C_IDLE, 1, 0, 0, 0, 0);
    step(0, C_PLAY, 1, 0, 0, 1, 0);
    step(0, C_DONE, 1, 0, 1, 0, 1);
    step(0, C_IDLE, 1, 0, 1, 1, 0);
    step(0, C_DONE, 0, 0, 2, 0, 1);
    step(0, C_IDLE, 0, 0, 2, 0, 0);
    step(0, C_DONE, 1, 0, 2, 0, 0);
    step(0, C_NXPL, 0, 0, 3, 0, 1);
    step(0, C_IDLE, 0, 0, 3, 0, 0);
    step(0, C_PLAY, 0, 0, 3, 1, 0);
    step(0, C_NXPV, 0, 0, 0, 0, 1);
    step(0, C_IDLE, 0, 0, 0, 0, 0);
    step(0, C_NEXT, 0, 0, 1, 0, 1);
    step(0, C_RST,  0, 0, 0, 0, 0);
    step(0, C_IDLE, 0, 0, 0, 0, 0);

`ifndef SONG_SHUFFLE_EN
    // Sequential repeat-all / repeat-one, autoplay, inputs ignored during RESTART
    step(0, C_NEXT, 0, 0, 1, 0, 1);
    step(0, C_IDLE, 0, 0, 1, 0, 0);
    step(0, C_PLAY, 1, 1, 1, 1, 0);
    step(0, C_DONE, 1, 1, 2, 0, 1);
    step(0, C_IDLE, 1, 1, 2, 1, 0);
    step(0, C_PREV, 0, 2, 1, 0, 1);
    step(0, C_IDLE, 0, 2, 1, 0, 0);
    step(0, C_PLAY, 0, 2, 1, 1, 0);
    step(0, C_DONE, 0, 2, 1, 0, 1);
    step(0, C_IDLE, 0, 2, 1, 1, 0);
    step(0, C_DONE, 0, 1, 2, 0, 1);
    step(0, C_IDLE, 0, 1, 2, 0, 0);
    step(0, C_PLAY, 1, 3, 2, 1, 0);
    step(0, C_DONE, 1, 3, 3, 0, 1);
    step(0, C_NEXT, 1, 3, 3, 1, 0);
    step(0, C_IDLE, 1, 3, 3, 1, 0);
    step(0, C_DONE, 1, 1, 0, 0, 1);
    step(0, C_IDLE, 1, 1, 0, 1, 0);
`endif

    // 5 songs: non-power-of-two wrap in both directions and stop at the last song
    step(1, C_RST,  0, 0, 0, 0, 0);
    step(1, C_IDLE, 0, 0, 0, 0, 0);
    step(1, C_PREV, 0, 0, 4, 0, 1);
    step(1, C_IDLE, 0, 0, 4, 0, 0);
    step(1, C_PREV, 0, 0, 3, 0, 1);
    step(1, C_IDLE, 0, 0, 3, 0, 0);
    step(1, C_NEXT, 0, 0, 4, 0, 1);
    step(1, C_IDLE, 0, 0, 4, 0, 0);
    step(1, C_NEXT, 0, 0, 0, 0, 1);
    step(1, C_IDLE, 0, 0, 0, 0, 0);
    step(1, C_PREV, 0, 0, 4, 0, 1);
    step(1, C_IDLE, 0, 0, 4, 0, 0);
    step(1, C_PLAY, 1, 0, 4, 1, 0);
    step(1, C_DONE, 1, 0, 0, 0, 1);
    step(1, C_IDLE, 1, 0, 0, 0, 0);

`ifdef SONG_SHUFFLE_EN
    step(1, C_RST,  0, 1, 0, 0, 0);
    step(1, C_IDLE, 0, 1, 0, 0, 0);
    begin
      logic [2:0] last_song;
      last_song = 3'd0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        in5 = mk(C_NEXT, 1'b0, 2'd1);
        @(posedge clk);
        #1;
        checks++;
        if ((song5 >= 3'd5) || (song5 == last_song) || (rp5 !== 1'b1)) begin
          errors++;
          $display("FAIL shuffle pick %0d: got song=%0d reset_player=%0b, previous song=%0d, required song<5, changed, reset_player=1",
                   i, song5, rp5, last_song);
        end
        last_song = song5;
        @(negedge clk);
        in5 = mk(C_IDLE, 1'b0, 2'd1);
      end
    end
`endif

    @(negedge clk);
    in4 = mk(C_IDLE, 1'b0, 2'd0);
    in5 = mk(C_IDLE, 1'b0, 2'd0);
    for (int i = 0; i < 10 && (q4.size() > 0 || q5.size() > 0); i++) begin
      @(posedge clk);
    end
    #2;
    if (q4.size() > 0 || q5.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left in scoreboard, expected 0", q4.size() + q5.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
